sipo_window: RTL

//   Parametrised serial-in / parallel-out buffer with valid/ready handshakes on both sides.

---
 rtl/sipo_window.sv | 90 +++++++++
 1 files changed

// File: rtl/sipo_window.sv
// Serial-in / parallel-out window buffer with valid/ready on both sides.
// Block mode emits non-overlapping frames; sliding mode emits a window per sample once full.
module sipo_window #(
    parameter int BIT   = 8,
    parameter int NDATA = 3,
    parameter int SLIDE = 0,
    parameter int CW    = $clog2(NDATA + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BIT-1:0]       i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BIT*NDATA-1:0] o_data,
    output logic [CW-1:0]        o_count
);

    localparam logic [CW-1:0] FULL    = CW'(NDATA);
    localparam logic [CW-1:0] NEARLY  = CW'(NDATA - 1);

    logic [BIT-1:0] elem [NDATA];
    logic           acc;
    logic           fire;
    logic [CW-1:0]  count_nxt;
    logic           valid_nxt;

    // A held window blocks new samples unless it is leaving this same cycle.
    assign o_ready = !i_clear && (!o_valid || i_ready);
    assign acc     = i_valid && o_ready;
    assign fire    = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NDATA; k++) begin
                elem[k] <= '0;
            end
        end else if (acc) begin
            for (int k = 0; k < NDATA - 1; k++) begin
                elem[k] <= elem[k+1];
            end
            elem[NDATA-1] <= i_data;
        end
    end

    always_comb begin
        count_nxt = o_count;
        valid_nxt = o_valid && !fire;
        if (SLIDE == 0) begin
            if (fire && acc) begin
                count_nxt = CW'(1);
            end else if (fire) begin
                count_nxt = '0;
            end else if (acc) begin
                count_nxt = o_count + CW'(1);
            end
            if (acc && count_nxt == FULL) begin
                valid_nxt = 1'b1;
            end
        end else begin
            // Count saturates at full; a downstream take never empties the window.
            if (acc && o_count != FULL) begin
                count_nxt = o_count + CW'(1);
            end
            if (acc && o_count >= NEARLY) begin
                valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            o_count <= '0;
            o_valid <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_valid <= valid_nxt;
        end
    end

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NDATA; k++) begin
            o_data[BIT*k +: BIT] = elem[k];
        end
    end

endmodule
